audio_codec_i2s: RTL and testbench

//  Codec-side end of the sample_req/sample_end/audio_output/audio_input interface used by
//  the audio effect blocks. Generates I2S BCLK/LRCK as clock master, requests one output

---
 rtl/audio_codec_i2s.sv | 125 ++++++++++++
 tb/tb_audio_codec_i2s.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_i2s.sv
// I2S clock-master codec interface: BCLK/LRCK generation, mono DAC serialiser
// and left-slot ADC deserialiser with sample_req/sample_end handshakes.
`timescale 1ns/1ps
module audio_codec_i2s #(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned BCLK_HALF = 2,
    parameter int unsigned REQ_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                sample_req,
    input  logic [SAMPLE_W-1:0] audio_output,
    output logic                sample_end,
    output logic [SAMPLE_W-1:0] audio_input,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_adclrck,
    output logic                aud_dacdat,
    input  logic                aud_adcdat
);

    localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned BC_W  = $clog2(SLOT_BITS);
    localparam int unsigned LAT_W = $clog2(REQ_LAT + 1);

    logic [DIV_W-1:0]    r_div;
    logic                r_bclk;
    logic                r_lrck;
    logic [BC_W-1:0]     r_bitcnt;
    logic                r_dacdat;
    logic                r_sample_req;
    logic                r_sample_end;
    logic [SAMPLE_W-1:0] r_audio_input;
    logic [SAMPLE_W-1:0] r_tx;
    logic [SAMPLE_W-1:0] r_rx;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_cap_done;

    logic                w_div_wrap;
    logic                w_rise;
    logic                w_fall;
    logic                w_slot_wrap;
    logic [BC_W-1:0]     w_bit_next;
    logic                w_next_in_word;
    logic                w_cur_in_word;
    logic [SAMPLE_W-1:0] w_tx_sh;
    logic                w_cap;
    logic                w_cap_last;

    assign w_div_wrap     = (r_div == DIV_W'(BCLK_HALF - 1));
    assign w_rise         = w_div_wrap && !r_bclk;
    assign w_fall         = w_div_wrap && r_bclk;
    assign w_slot_wrap    = (r_bitcnt == BC_W'(SLOT_BITS - 1));
    assign w_bit_next     = w_slot_wrap ? '0 : r_bitcnt + BC_W'(1);
    assign w_next_in_word = (w_bit_next != '0) && (w_bit_next <= BC_W'(SAMPLE_W));
    assign w_cur_in_word  = (r_bitcnt != '0) && (r_bitcnt <= BC_W'(SAMPLE_W));
    // Slot bit b carries tx[SAMPLE_W-b]; shifting left by b-1 brings it to the MSB.
    assign w_tx_sh        = r_tx << (w_bit_next - BC_W'(1));
    assign w_cap          = w_rise && !r_lrck && w_cur_in_word;
    assign w_cap_last     = w_rise && !r_lrck && (r_bitcnt == BC_W'(SAMPLE_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div         <= '0;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b1;
            r_bitcnt      <= '0;
            r_dacdat      <= 1'b0;
            r_sample_req  <= 1'b0;
            r_sample_end  <= 1'b0;
            r_audio_input <= '0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_lat_cnt     <= '0;
            r_cap_done    <= 1'b0;
        end else begin
            r_sample_req <= 1'b0;
            r_sample_end <= 1'b0;

            if (w_div_wrap) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                if (r_lat_cnt == LAT_W'(1))
                    r_tx <= audio_output;
            end

            if (w_fall) begin
                r_bitcnt <= w_bit_next;
                r_dacdat <= w_next_in_word ? w_tx_sh[SAMPLE_W-1] : 1'b0;
                if (w_slot_wrap) begin
                    r_lrck <= ~r_lrck;
                    if (r_lrck) begin
                        r_sample_req <= 1'b1;
                        r_lat_cnt    <= LAT_W'(REQ_LAT);
                    end
                end
            end

            if (w_cap)
                r_rx <= {r_rx[SAMPLE_W-2:0], aud_adcdat};

            r_cap_done <= w_cap_last;
            if (r_cap_done) begin
                r_audio_input <= r_rx;
                r_sample_end  <= 1'b1;
            end
        end
    end

    assign sample_req  = r_sample_req;
    assign sample_end  = r_sample_end;
    assign audio_input = r_audio_input;
    assign aud_bclk    = r_bclk;
    assign aud_daclrck = r_lrck;
    assign aud_adclrck = r_lrck;
    assign aud_dacdat  = r_dacdat;

endmodule

// File: tb/tb_audio_codec_i2s.sv
// Bench for audio_codec_i2s: every output is predicted each cycle from the
// number of clocks since reset release and per-frame sample tables.
`timescale 1ns/1ps
module tb_audio_codec_i2s;

    localparam int W         = 16;
    localparam int SLOT      = 32;
    localparam int HALF      = 2;
    localparam int LAT       = 1;
    localparam int FIRST_REQ = SLOT * 2 * HALF;
    localparam int FRAME     = 2 * FIRST_REQ;
    localparam int SE0       = FIRST_REQ + W * 2 * HALF + HALF + 1;
    localparam int NF        = 8;

    logic         clk;
    logic         reset_n;
    logic         sample_req;
    logic [W-1:0] audio_output;
    logic         sample_end;
    logic [W-1:0] audio_input;
    logic         aud_bclk;
    logic         aud_daclrck;
    logic         aud_adclrck;
    logic         aud_dacdat;
    logic         aud_adcdat;

    logic [W-1:0] dac_word  [NF];
    logic [W-1:0] adc_left  [NF];
    logic [W-1:0] adc_right [NF];
    logic [W-1:0] tog_val   [NF];
    bit           tog       [NF];

    int t;
    int n_tests;
    int n_fail;

    audio_codec_i2s #(
        .SAMPLE_W (W),
        .SLOT_BITS(SLOT),
        .BCLK_HALF(HALF),
        .REQ_LAT  (LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_req  (sample_req),
        .audio_output(audio_output),
        .sample_end  (sample_end),
        .audio_input (audio_input),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_adclrck (aud_adclrck),
        .aud_dacdat  (aud_dacdat),
        .aud_adcdat  (aud_adcdat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_bclk"},   W'(aud_bclk),    '0);
        check({tag, "_dlrck"},  W'(aud_daclrck), W'(1));
        check({tag, "_alrck"},  W'(aud_adclrck), W'(1));
        check({tag, "_dacdat"}, W'(aud_dacdat),  '0);
        check({tag, "_req"},    W'(sample_req),  '0);
        check({tag, "_end"},    W'(sample_end),  '0);
        check({tag, "_ain"},    audio_input,     '0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NF; i++) begin
            dac_word[i]  = W'($urandom);
            adc_left[i]  = W'($urandom);
            adc_right[i] = W'($urandom);
            tog_val[i]   = '0;
            tog[i]       = 1'b0;
        end
    endtask

    // Inputs for the interval following clock t: audio_output per frame, ADC serial bit.
    task automatic drive_inputs();
        int n, b, f;
        logic [W-1:0] w;
        n = t / (2 * HALF);
        if (t >= FIRST_REQ - 10 && (t - (FIRST_REQ - 10)) % FRAME == 0) begin
            f = (t - (FIRST_REQ - 10)) / FRAME;
            if (f < NF) audio_output = dac_word[f];
        end
        if (t >= FIRST_REQ + 2 && (t - FIRST_REQ - 2) % FRAME == 0) begin
            f = (t - FIRST_REQ - 2) / FRAME;
            if (f < NF && tog[f]) audio_output = tog_val[f];
        end
        b = n % SLOT;
        if (n < SLOT) begin
            w = '1;
        end else begin
            f = (n - SLOT) / (2 * SLOT);
            if (f >= NF)                          w = '1;
            else if (((n - SLOT) % (2 * SLOT)) < SLOT) w = adc_left[f];
            else                                  w = adc_right[f];
        end
        if (b >= 1 && b <= W) aud_adcdat = w[4'(W - b)];
        else                  aud_adcdat = 1'($urandom);
    endtask

    task automatic step();
        int n, b, f;
        logic [W-1:0] w;
        logic e_bit;
        @(posedge clk);
        t++;
        #1;
        n = t / (2 * HALF);
        b = n % SLOT;
        check("bclk",   W'(aud_bclk),    W'((t / HALF) % 2));
        check("dlrck",  W'(aud_daclrck), W'((n / SLOT) % 2 == 0));
        check("alrck",  W'(aud_adclrck), W'((n / SLOT) % 2 == 0));
        check("req",    W'(sample_req),  W'(t >= FIRST_REQ && (t - FIRST_REQ) % FRAME == 0));
        e_bit = 1'b0;
        if (n >= SLOT && b >= 1 && b <= W) begin
            f = (n - SLOT) / (2 * SLOT);
            w = dac_word[f];
            e_bit = w[4'(W - b)];
        end
        check("dacdat", W'(aud_dacdat),  W'(e_bit));
        check("end",    W'(sample_end),  W'(t >= SE0 && (t - SE0) % FRAME == 0));
        w = (t < SE0) ? '0 : adc_left[(t - SE0) / FRAME];
        check("ain",    audio_input,     w);
        drive_inputs();
    endtask

    initial begin
        clk          = 1'b0;
        reset_n      = 1'b0;
        audio_output = '0;
        aud_adcdat   = 1'b0;
        t            = 0;
        n_tests      = 0;
        n_fail       = 0;

        repeat (3) @(negedge clk);
        check_reset("rst");

        // Directed frames: A5C3 pattern, late-change mono frame, then MSB/LSB boundaries.
        fill_random();
        dac_word[0]  = 16'hA5C3;
        adc_left[0]  = 16'h8001;
        adc_right[0] = 16'hFFFF;
        dac_word[1]  = 16'h1234;
        tog[1]       = 1'b1;
        tog_val[1]   = 16'hFFFF;
        dac_word[2]  = 16'hFFFF;
        adc_right[2] = 16'hFFFF;
        dac_word[3]  = 16'h8000;
        adc_left[3]  = 16'h8000;
        dac_word[4]  = 16'h7FFF;
        adc_left[4]  = 16'h7FFF;

        drive_inputs();
        reset_n = 1'b1;
        // Stop one cycle after the 8th left ADC bit of frame 6 has been shifted in.
        repeat (FIRST_REQ + 6 * FRAME + (8 * 2 * HALF + HALF + 1)) step();

        reset_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) @(negedge clk);
        check_reset("hold");

        fill_random();
        t = 0;
        drive_inputs();
        reset_n = 1'b1;
        repeat (FIRST_REQ + 2 * FRAME) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
